rf_channel_monitor: RTL and testbench

Parametrised successor of the fixed 8x8x16 ADC/DAC monitor.
- Registers N ADC AXI-Stream channels and drives N DAC AXI-Stream channels with proper tready back-pressure.
- Exposes one selectable monitor tap per direction, lane-sliced.
- Adds a triggered snapshot-hold FSM and an absolute-peak tracker on the ADC tap.
- Sits between the RF data converter IP and user DSP and debug logic (ILA/VIO).

---
 rtl/rf_monitor_pkg.sv | 32 +++
 rtl/rf_stream_out_reg.sv | 29 ++
 rtl/rf_channel_monitor.sv | 149 ++++++++++++++
 tb/tb_rf_channel_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_monitor_pkg.sv
// Shared definitions for the RF channel monitor.
//   - capture FSM state encodings (FREE / ARMED / HOLD)
//   - abs_sat : saturating absolute value of a signed sample of run-time width
//   - lane_offset : bit offset of a lane inside a packed stream word
package rf_monitor_pkg;

    localparam logic [1:0] CAP_FREE  = 2'd0;
    localparam logic [1:0] CAP_ARMED = 2'd1;
    localparam logic [1:0] CAP_HOLD  = 2'd2;

    // Sample arrives zero-extended in the low 'width' bits. The result is the
    // magnitude in the low width-1 bits; the most-negative code saturates to
    // the largest positive magnitude instead of wrapping back to zero.
    function automatic logic [31:0] abs_sat(input logic [31:0] sample,
                                            input int unsigned width);
        logic [31:0] mag_mask;
        logic [31:0] mag;
        mag_mask = (32'd1 << (width - 1)) - 32'd1;
        if (sample[width-1]) begin
            mag = (~sample + 32'd1) & mag_mask;
            if (mag == 32'd0) mag = mag_mask;
        end else begin
            mag = sample & mag_mask;
        end
        return mag;
    endfunction

    function automatic int lane_offset(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rf_stream_out_reg.sv
// One AXI-Stream output register stage.
//   clock, resetn : clock and async active-low reset
//   data          : word offered by user logic every cycle
//   tvalid, tdata : registered stream output
//   tready        : downstream ready
// Loads whenever the slot is empty or being drained, so tdata is stable
// for as long as tvalid=1 and tready=0.
module rf_stream_out_reg #(
    parameter int WIDTH = 128
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data,
    output logic             tvalid,
    output logic [WIDTH-1:0] tdata,
    input  logic             tready
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (!tvalid || tready) begin
            tvalid <= 1'b1;
            tdata  <= data;
        end
    end

endmodule

// File: rtl/rf_channel_monitor.sv
// Registered ADC/DAC stream bridge with per-direction monitor taps, a
// triggered snapshot-hold on the ADC tap and an absolute-peak tracker.
//   adc_in_*   : ADC streams in (per channel), adc_data/adc_data_valid out
//   dac_data   : user DAC words, dac_out_* : DAC streams out
//   *_monitor_select / *_monitor_lines : tap select and tapped word
//   capture_arm, trigger_level, capture_state : snapshot control/status
//   adc_peak, peak_clear : max |sample| seen on the ADC tap
//
// state | meaning
// FREE  | tap follows live ADC data, trigger ignored
// ARMED | tap follows live data, waiting for |sample| >= trigger_level
// HOLD  | tap frozen on the triggering word until capture_arm drops
module rf_channel_monitor
    import rf_monitor_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int NUM_LANES    = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SEL_W        = 3
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic [NUM_CH-1:0]                     adc_in_tvalid,
    input  logic [NUM_CH*NUM_LANES*SAMPLE_WIDTH-1:0] adc_in_tdata,
    output logic [NUM_CH-1:0]                     adc_in_tready,
    output logic [NUM_CH*NUM_LANES*SAMPLE_WIDTH-1:0] adc_data,
    output logic [NUM_CH-1:0]                     adc_data_valid,
    input  logic [NUM_CH*NUM_LANES*SAMPLE_WIDTH-1:0] dac_data,
    output logic [NUM_CH-1:0]                     dac_out_tvalid,
    output logic [NUM_CH*NUM_LANES*SAMPLE_WIDTH-1:0] dac_out_tdata,
    input  logic [NUM_CH-1:0]                     dac_out_tready,
    input  logic [SEL_W-1:0]                      adc_monitor_select,
    input  logic [SEL_W-1:0]                      dac_monitor_select,
    output logic [NUM_LANES*SAMPLE_WIDTH-1:0]     adc_monitor_lines,
    output logic [NUM_LANES*SAMPLE_WIDTH-1:0]     dac_monitor_lines,
    input  logic                                  capture_arm,
    input  logic [SAMPLE_WIDTH-2:0]               trigger_level,
    output logic [1:0]                            capture_state,
    output logic [SAMPLE_WIDTH-2:0]               adc_peak,
    input  logic                                  peak_clear
);

    localparam int WORD_W = NUM_LANES * SAMPLE_WIDTH;
    localparam int MAG_W  = SAMPLE_WIDTH - 1;

    logic [SEL_W-1:0]  adc_sel_q, dac_sel_q, adc_sel_next, dac_sel_next;
    logic [WORD_W-1:0] tap_word, dac_tap_word;
    logic              tap_valid;
    logic [MAG_W-1:0]  tap_max;
    logic              trig_hit;
    logic [1:0]        state_next;

    // ADC path
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            adc_in_tready  <= '0;
            adc_data       <= '0;
            adc_data_valid <= '0;
        end else begin
            adc_in_tready <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                adc_data_valid[c] <= adc_in_tvalid[c] & adc_in_tready[c];
                if (adc_in_tvalid[c] && adc_in_tready[c])
                    adc_data[c*WORD_W +: WORD_W] <= adc_in_tdata[c*WORD_W +: WORD_W];
            end
        end
    end

    // DAC path
    for (genvar c = 0; c < NUM_CH; c++) begin : g_dac
        rf_stream_out_reg #(.WIDTH(WORD_W)) u_out (
            .clock  (clock),
            .resetn (resetn),
            .data   (dac_data[c*WORD_W +: WORD_W]),
            .tvalid (dac_out_tvalid[c]),
            .tdata  (dac_out_tdata[c*WORD_W +: WORD_W]),
            .tready (dac_out_tready[c])
        );
    end

    // Out-of-range selects fold onto channel 0 before registering, so a
    // change between two aliases of channel 0 does not clear the peak.
    always_comb begin
        adc_sel_next = (int'(adc_monitor_select) < NUM_CH) ? adc_monitor_select : '0;
        dac_sel_next = (int'(dac_monitor_select) < NUM_CH) ? dac_monitor_select : '0;
    end

    always_comb begin
        tap_word     = '0;
        tap_valid    = 1'b0;
        dac_tap_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(adc_sel_q) == c) begin
                tap_word  = adc_data[c*WORD_W +: WORD_W];
                tap_valid = adc_data_valid[c];
            end
            if (int'(dac_sel_q) == c)
                dac_tap_word = dac_data[c*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        logic [MAG_W-1:0] mag;
        tap_max  = '0;
        trig_hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            mag = MAG_W'(abs_sat(32'(tap_word[lane_offset(l, SAMPLE_WIDTH) +: SAMPLE_WIDTH]),
                                 SAMPLE_WIDTH));
            if (mag > tap_max)        tap_max  = mag;
            if (mag >= trigger_level) trig_hit = 1'b1;
        end
        trig_hit = trig_hit & tap_valid;
    end

    always_comb begin
        state_next = capture_state;
        case (capture_state)
            CAP_FREE:  if (capture_arm) state_next = CAP_ARMED;
            CAP_ARMED: if (!capture_arm)  state_next = CAP_FREE;
                       else if (trig_hit) state_next = CAP_HOLD;
            CAP_HOLD:  if (!capture_arm) state_next = CAP_FREE;
            default:   state_next = CAP_FREE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            adc_sel_q         <= '0;
            dac_sel_q         <= '0;
            capture_state     <= CAP_FREE;
            adc_monitor_lines <= '0;
            dac_monitor_lines <= '0;
            adc_peak          <= '0;
        end else begin
            adc_sel_q         <= adc_sel_next;
            dac_sel_q         <= dac_sel_next;
            capture_state     <= state_next;
            dac_monitor_lines <= dac_tap_word;
            // The ARMED->HOLD edge still loads, capturing the triggering word.
            if (capture_state != CAP_HOLD)
                adc_monitor_lines <= tap_word;
            if (peak_clear || (adc_sel_next != adc_sel_q))
                adc_peak <= '0;
            else if (tap_valid && (tap_max > adc_peak))
                adc_peak <= tap_max;
        end
    end

endmodule

// File: tb/tb_rf_channel_monitor.sv
module tb_rf_channel_monitor;

    localparam int NCH = 6;
    localparam int NL  = 8;
    localparam int SW  = 16;
    localparam int WW  = NL * SW;

    logic               clock = 1'b0;
    logic               resetn;
    logic [NCH-1:0]     adc_in_tvalid;
    logic [NCH*WW-1:0]  adc_in_tdata;
    logic [NCH-1:0]     adc_in_tready;
    logic [NCH*WW-1:0]  adc_data;
    logic [NCH-1:0]     adc_data_valid;
    logic [NCH*WW-1:0]  dac_data;
    logic [NCH-1:0]     dac_out_tvalid;
    logic [NCH*WW-1:0]  dac_out_tdata;
    logic [NCH-1:0]     dac_out_tready;
    logic [2:0]         adc_monitor_select;
    logic [2:0]         dac_monitor_select;
    logic [WW-1:0]      adc_monitor_lines;
    logic [WW-1:0]      dac_monitor_lines;
    logic               capture_arm;
    logic [SW-2:0]      trigger_level;
    logic [1:0]         capture_state;
    logic [SW-2:0]      adc_peak;
    logic               peak_clear;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rf_channel_monitor #(
        .NUM_CH(NCH), .NUM_LANES(NL), .SAMPLE_WIDTH(SW), .SEL_W(3)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .adc_in_tvalid      (adc_in_tvalid),
        .adc_in_tdata       (adc_in_tdata),
        .adc_in_tready      (adc_in_tready),
        .adc_data           (adc_data),
        .adc_data_valid     (adc_data_valid),
        .dac_data           (dac_data),
        .dac_out_tvalid     (dac_out_tvalid),
        .dac_out_tdata      (dac_out_tdata),
        .dac_out_tready     (dac_out_tready),
        .adc_monitor_select (adc_monitor_select),
        .dac_monitor_select (dac_monitor_select),
        .adc_monitor_lines  (adc_monitor_lines),
        .dac_monitor_lines  (dac_monitor_lines),
        .capture_arm        (capture_arm),
        .trigger_level      (trigger_level),
        .capture_state      (capture_state),
        .adc_peak           (adc_peak),
        .peak_clear         (peak_clear)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_adc(input int ch, input int lane, input logic [SW-1:0] v);
        adc_in_tdata[(ch*NL+lane)*SW +: SW] = v;
    endtask

    task automatic set_dac(input int ch, input int lane, input logic [SW-1:0] v);
        dac_data[(ch*NL+lane)*SW +: SW] = v;
    endtask

    function automatic logic [SW-1:0] adc_lane(input int ch, input int lane);
        return adc_data[(ch*NL+lane)*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] dac_lane(input int ch, input int lane);
        return dac_out_tdata[(ch*NL+lane)*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] tap_lane(input int lane);
        return adc_monitor_lines[lane*SW +: SW];
    endfunction

    task automatic test_reset();
        resetn             = 1'b0;
        adc_in_tvalid      = '1;
        adc_in_tdata       = '0;
        dac_data           = '0;
        dac_out_tready     = '1;
        adc_monitor_select = 3'd3;
        dac_monitor_select = 3'd5;
        capture_arm        = 1'b0;
        trigger_level      = 15'd1000;
        peak_clear         = 1'b0;
        set_adc(3, 0, 16'h1234);
        #12;
        checks++; if (adc_in_tready !== '0) begin errors++; $display("FAIL reset_tready got %h exp 0", adc_in_tready); end
        checks++; if (dac_out_tvalid !== '0) begin errors++; $display("FAIL reset_tvalid got %h exp 0", dac_out_tvalid); end
        checks++; if (capture_state !== 2'd0 || adc_peak !== '0 || adc_monitor_lines !== '0 || adc_data !== '0)
            begin errors++; $display("FAIL reset_state state %0d peak %h exp all 0", capture_state, adc_peak); end
        @(posedge clock); #1;
        resetn = 1'b1;
        tick();
        checks++; if (adc_in_tready !== 6'h3F) begin errors++; $display("FAIL tready_rise got %h exp 3f", adc_in_tready); end
        checks++; if (dac_out_tvalid !== 6'h3F) begin errors++; $display("FAIL dac_tvalid_rise got %h exp 3f", dac_out_tvalid); end
        checks++; if (adc_data_valid !== 6'h00) begin errors++; $display("FAIL no_accept_first got %h exp 00", adc_data_valid); end
        tick();
        checks++; if (adc_lane(3, 0) !== 16'h1234 || adc_data_valid !== 6'h3F)
            begin errors++; $display("FAIL adc_latency got %h/%h exp 1234/3f", adc_lane(3, 0), adc_data_valid); end
        tick();
        checks++; if (tap_lane(0) !== 16'h1234) begin errors++; $display("FAIL tap_latency got %h exp 1234", tap_lane(0)); end
    endtask

    task automatic test_dac_stall();
        set_dac(5, 0, 16'h00AA);
        tick();
        checks++; if (dac_lane(5, 0) !== 16'h00AA) begin errors++; $display("FAIL dac_load got %h exp 00aa", dac_lane(5, 0)); end
        dac_out_tready[5] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_dac(5, 0, 16'(k));
            tick();
            checks++; if (dac_lane(5, 0) !== 16'h00AA || dac_out_tvalid[5] !== 1'b1)
                begin errors++; $display("FAIL dac_stall_%0d got %h exp 00aa", k, dac_lane(5, 0)); end
        end
        dac_out_tready[5] = 1'b1;
        tick();
        checks++; if (dac_lane(5, 0) !== 16'h0004) begin errors++; $display("FAIL dac_resume got %h exp 0004", dac_lane(5, 0)); end
        checks++; if (dac_monitor_lines[15:0] !== 16'h0004) begin errors++; $display("FAIL dac_tap got %h exp 0004", dac_monitor_lines[15:0]); end
    endtask

    task automatic test_capture();
        adc_monitor_select = 3'd0;
        for (int l = 0; l < NL; l++) set_adc(0, l, (l % 2 == 0) ? 16'h0064 : 16'hFF9C);
        tick(3);
        capture_arm = 1'b1;
        tick();
        checks++; if (capture_state !== 2'd1) begin errors++; $display("FAIL cap_armed got %0d exp 1", capture_state); end
        set_adc(0, 6, 16'hFB50);
        tick();
        checks++; if (capture_state !== 2'd1) begin errors++; $display("FAIL cap_still_armed got %0d exp 1", capture_state); end
        tick();
        checks++; if (capture_state !== 2'd2 || tap_lane(6) !== 16'hFB50)
            begin errors++; $display("FAIL cap_hold got %0d/%h exp 2/fb50", capture_state, tap_lane(6)); end
        set_adc(0, 6, 16'h0005);
        adc_monitor_select = 3'd2;
        tick(3);
        checks++; if (capture_state !== 2'd2 || tap_lane(6) !== 16'hFB50 || tap_lane(0) !== 16'h0064)
            begin errors++; $display("FAIL cap_frozen got %0d/%h exp 2/fb50", capture_state, tap_lane(6)); end
        adc_monitor_select = 3'd0;
        tick(2);
        capture_arm = 1'b0;
        tick();
        checks++; if (capture_state !== 2'd0) begin errors++; $display("FAIL cap_release got %0d exp 0", capture_state); end
        tick();
        checks++; if (tap_lane(6) !== 16'h0005) begin errors++; $display("FAIL cap_live got %h exp 0005", tap_lane(6)); end
        set_adc(0, 6, 16'hFB50);
        tick(2);
        checks++; if (tap_lane(6) !== 16'hFB50) begin errors++; $display("FAIL free_live got %h exp fb50", tap_lane(6)); end
        capture_arm = 1'b1;
        tick();
        checks++; if (capture_state !== 2'd1) begin errors++; $display("FAIL arm_no_trig got %0d exp 1", capture_state); end
        capture_arm = 1'b0;
        tick();
        checks++; if (capture_state !== 2'd0) begin errors++; $display("FAIL disarm got %0d exp 0", capture_state); end
    endtask

    task automatic test_peak();
        peak_clear = 1'b1;
        tick();
        checks++; if (adc_peak !== 15'h0000) begin errors++; $display("FAIL peak_clear got %h exp 0", adc_peak); end
        peak_clear = 1'b0;
        for (int l = 0; l < NL; l++) set_adc(0, l, 16'h0010);
        set_adc(0, 2, 16'h8000);
        tick(2);
        checks++; if (adc_peak !== 15'h7FFF) begin errors++; $display("FAIL peak_sat got %h exp 7fff", adc_peak); end
        for (int l = 0; l < NL; l++) set_adc(0, l, 16'h0032);
        peak_clear = 1'b1;
        tick();
        checks++; if (adc_peak !== 15'h0000) begin errors++; $display("FAIL peak_clear_prio got %h exp 0", adc_peak); end
        peak_clear = 1'b0;
        tick();
        checks++; if (adc_peak !== 15'h0032) begin errors++; $display("FAIL peak_small got %h exp 0032", adc_peak); end
        set_adc(0, 3, 16'hFC18);
        tick(2);
        checks++; if (adc_peak !== 15'h03E8) begin errors++; $display("FAIL peak_neg got %h exp 03e8", adc_peak); end
    endtask

    task automatic test_select();
        for (int l = 0; l < NL; l++) set_adc(0, l, 16'h0000);
        set_adc(0, 0, 16'h0A0A);
        set_dac(0, 0, 16'h5555);
        adc_monitor_select = 3'd3;
        tick(2);
        checks++; if (tap_lane(0) !== 16'h1234) begin errors++; $display("FAIL sel3_tap got %h exp 1234", tap_lane(0)); end
        adc_monitor_select = 3'd7;
        dac_monitor_select = 3'd7;
        tick();
        checks++; if (adc_peak !== 15'h0000) begin errors++; $display("FAIL sel_change_clear got %h exp 0", adc_peak); end
        tick();
        checks++; if (tap_lane(0) !== 16'h0A0A) begin errors++; $display("FAIL sel7_adc_tap got %h exp 0a0a", tap_lane(0)); end
        checks++; if (dac_monitor_lines[15:0] !== 16'h5555) begin errors++; $display("FAIL sel7_dac_tap got %h exp 5555", dac_monitor_lines[15:0]); end
        checks++; if (adc_peak !== 15'h0A0A) begin errors++; $display("FAIL sel7_peak got %h exp 0a0a", adc_peak); end
        adc_monitor_select = 3'd2;
        tick();
        checks++; if (adc_peak !== 15'h0000) begin errors++; $display("FAIL sel02_clear got %h exp 0", adc_peak); end
    endtask

    task automatic test_async_reset();
        for (int l = 0; l < NL; l++) set_adc(0, l, 16'h0000);
        set_adc(0, 6, 16'hFB50);
        adc_monitor_select = 3'd0;
        tick(2);
        capture_arm = 1'b1;
        tick(2);
        checks++; if (capture_state !== 2'd2) begin errors++; $display("FAIL pre_reset_hold got %0d exp 2", capture_state); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (adc_in_tready !== '0 || adc_data_valid !== '0 || adc_data !== '0)
            begin errors++; $display("FAIL async_adc got %h/%h exp 0", adc_in_tready, adc_data_valid); end
        checks++; if (dac_out_tvalid !== '0 || dac_out_tdata !== '0)
            begin errors++; $display("FAIL async_dac got %h exp 0", dac_out_tvalid); end
        checks++; if (capture_state !== 2'd0 || adc_peak !== '0 || adc_monitor_lines !== '0 || dac_monitor_lines !== '0)
            begin errors++; $display("FAIL async_mon got %0d/%h exp 0/0", capture_state, adc_peak); end
        capture_arm = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        tick();
        checks++; if (capture_state !== 2'd0 || adc_in_tready !== 6'h3F)
            begin errors++; $display("FAIL post_reset got %0d/%h exp 0/3f", capture_state, adc_in_tready); end
    endtask

    initial begin
        test_reset();
        test_dac_stall();
        test_capture();
        test_peak();
        test_select();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
